// File: rtl/drum_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module      : drum_mult_pipe
// Description : Three-stage DRUM approximate multiplier with valid/ready flow
//               control. Define DRUM_SIGNED_EN for two's-complement operands.
// Revision    : 1.0 - initial release
// ============================================================================
module drum_mult_pipe #(
    parameter int WIDTH = 16,
    parameter int K     = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] r
);

    localparam int SW = $clog2(WIDTH);
    localparam int PW = 2 * K;
    localparam int RW = 2 * WIDTH;
    localparam logic [SW-1:0] c_k    = SW'(K);
    localparam logic [SW-1:0] c_k_m1 = SW'(K - 1);

    typedef struct packed {
        logic [K-1:0]  mant;
        logic [SW-1:0] shift;
    } enc_t;

    // Leading-one detect, then either keep the low K bits (exact) or take the
    // top K-1 bits from the leading one with a forced-1 unbiasing LSB.
    function automatic enc_t drum_enc(input logic [WIDTH-1:0] x);
        enc_t          e;
        logic [SW-1:0] lead;
        lead = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (x[i]) lead = SW'(i);
        end
        if (lead >= c_k) begin
            e.shift = lead - c_k_m1;
            e.mant  = K'(x >> e.shift) | K'(1);
        end else begin
            e.shift = '0;
            e.mant  = x[K-1:0];
        end
        return e;
    endfunction

    logic             r_v1, r_v2, r_v3;
    logic             w_ld1, w_ld2, w_ld3, w_acc;
    logic [WIDTH-1:0] w_mag_a, w_mag_b;
    enc_t             w_enc_a, w_enc_b;
    logic [K-1:0]     r_ma, r_mb;
    logic [SW-1:0]    r_sa, r_sb;
    logic [PW-1:0]    w_prod, r_prod;
    logic [SW:0]      w_ssum, r_ssum;
    logic [RW-1:0]    w_shifted, w_res, r_res;

    // A stage may load when empty or when its successor takes its contents.
    assign w_ld3    = !r_v3 || out_ready;
    assign w_ld2    = !r_v2 || w_ld3;
    assign w_ld1    = !r_v1 || w_ld2;
    assign in_ready = w_ld1;
    assign w_acc    = in_valid && w_ld1;

`ifdef DRUM_SIGNED_EN
    logic w_neg, r_neg1, r_neg2;
    // The most negative value maps to 2^(WIDTH-1), still a valid unsigned magnitude.
    assign w_mag_a = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
    assign w_mag_b = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
    assign w_neg   = a[WIDTH-1] ^ b[WIDTH-1];
`else
    assign w_mag_a = a;
    assign w_mag_b = b;
`endif

    assign w_enc_a   = drum_enc(w_mag_a);
    assign w_enc_b   = drum_enc(w_mag_b);
    assign w_prod    = {{K{1'b0}}, r_ma} * {{K{1'b0}}, r_mb};
    assign w_ssum    = {1'b0, r_sa} + {1'b0, r_sb};
    assign w_shifted = {{(RW - PW){1'b0}}, r_prod} << r_ssum;

`ifdef DRUM_SIGNED_EN
    // Negating zero yields zero, so no negative zero can be emitted.
    assign w_res = r_neg2 ? (~w_shifted + RW'(1)) : w_shifted;
`else
    assign w_res = w_shifted;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else begin
            if (w_ld1) r_v1 <= in_valid;
            if (w_ld2) r_v2 <= r_v1;
            if (w_ld3) r_v3 <= r_v2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ma   <= '0;
            r_mb   <= '0;
            r_sa   <= '0;
            r_sb   <= '0;
            r_prod <= '0;
            r_ssum <= '0;
            r_res  <= '0;
        end else begin
            if (w_acc) begin
                r_ma <= w_enc_a.mant;
                r_mb <= w_enc_b.mant;
                r_sa <= w_enc_a.shift;
                r_sb <= w_enc_b.shift;
            end
            if (w_ld2 && r_v1) begin
                r_prod <= w_prod;
                r_ssum <= w_ssum;
            end
            if (w_ld3 && r_v2) begin
                r_res <= w_res;
            end
        end
    end

`ifdef DRUM_SIGNED_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_neg1 <= 1'b0;
            r_neg2 <= 1'b0;
        end else begin
            if (w_acc)          r_neg1 <= w_neg;
            if (w_ld2 && r_v1)  r_neg2 <= r_neg1;
        end
    end
`endif

    assign out_valid = r_v3;
    assign r         = r_res;

endmodule
`default_nettype wire

// File: tb/tb_drum_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_drum_mult_pipe
// Description : Self-checking bench for drum_mult_pipe (vectors, flow control,
//               reset and randomized traffic against a reference model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_drum_mult_pipe;

    localparam int W  = 16;
    localparam int KM = 6;

    logic           clk       = 1'b0;
    logic           rst_n     = 1'b0;
    logic           in_valid  = 1'b0;
    logic           out_ready = 1'b0;
    logic [W-1:0]   a         = '0;
    logic [W-1:0]   b         = '0;
    logic           in_ready;
    logic           out_valid;
    logic [2*W-1:0] r;

    int n_cmp = 0;
    int n_err = 0;
    int n_out = 0;
    int n_acc = 0;
    bit sb_en = 1'b0;
    logic [2*W-1:0] expq[$];

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp;
        string          name;
    } vec_t;

`ifdef DRUM_SIGNED_EN
    localparam int NV = 9;
`else
    localparam int NV = 7;
`endif
    vec_t vecs[NV];

    drum_mult_pipe #(.WIDTH(W), .K(KM)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Operand approximation straight from the arithmetic definition.
    function automatic void approx(input longint unsigned x, output longint unsigned m, output int s);
        int k;
        k = 0;
        for (int i = 0; i < W; i++) if (x >= (64'd1 << i)) k = i;
        if (x < (64'd1 << KM)) begin
            m = x;
            s = 0;
        end else begin
            s = k - KM + 1;
            m = (x >> s) | 64'd1;
        end
    endfunction

    function automatic logic [2*W-1:0] ref_mult(input logic [W-1:0] x, input logic [W-1:0] y);
        longint unsigned mx, my, ma, mb, res;
        int sa, sb;
        bit neg;
        mx  = 64'(x);
        my  = 64'(y);
        neg = 1'b0;
`ifdef DRUM_SIGNED_EN
        if (x[W-1]) mx = (64'd1 << W) - mx;
        if (y[W-1]) my = (64'd1 << W) - my;
        neg = x[W-1] ^ y[W-1];
`endif
        approx(mx, ma, sa);
        approx(my, mb, sb);
        res = (ma * mb) << (sa + sb);
        if (neg) res = -res;
        return res[2*W-1:0];
    endfunction

    function automatic logic [W-1:0] rand_op();
        logic [W-1:0] v;
        v = W'($urandom);
        case ($urandom % 5)
            0: v = v & 16'h003F;
            1: v = v & 16'h00FF;
            2: v = v;
            3: v = 16'h0000;
            default: begin
                case ($urandom % 3)
                    0: v = 16'hFFFF;
                    1: v = 16'h8000;
                    default: v = 16'h0040;
                endcase
            end
        endcase
        return v;
    endfunction

    // Scoreboard: handshakes sampled on the rising edge.
    always @(posedge clk) begin
        if (sb_en && rst_n) begin
            if (in_valid && in_ready) begin
                expq.push_back(ref_mult(a, b));
                n_acc++;
            end
            if (out_valid && out_ready) begin
                n_out++;
                chk("sb_pending", 64'(expq.size() != 0), 64'd1);
                if (expq.size() != 0) chk("sb_data", 64'(r), 64'(expq.pop_front()));
            end
        end
    end

    // Drives one pair into an empty pipe and checks latency and value.
    task automatic run_vec(input vec_t v);
        int lat;
        @(negedge clk);
        a = v.a;
        b = v.b;
        in_valid = 1'b1;
        chk({v.name, "_rdy"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        lat = 1;
        #1 in_valid = 1'b0;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({v.name, "_lat"}, 64'(lat), 64'd3);
        chk({v.name, "_r"}, 64'(r), 64'(v.exp));
        @(posedge clk);
        #1;
        chk({v.name, "_drain"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int   base, rdy_drop, stale, wait_cyc;
        logic [2*W-1:0] held;

        vecs[0] = '{16'd37,   16'd21,   32'd777,  "exact"};
        vecs[1] = '{16'h00FF, 16'd3,    32'd756,  "trunc_a"};
        vecs[2] = '{16'h0000, 16'h1234, 32'd0,    "zero_a"};
        vecs[3] = '{16'h1234, 16'h0000, 32'd0,    "zero_b"};
        vecs[4] = '{16'd63,   16'd63,   32'd3969, "exact_top"};
        vecs[5] = '{16'd64,   16'd64,   32'd4356, "trunc_first"};
`ifdef DRUM_SIGNED_EN
        vecs[6] = '{16'hFFFF, 16'hFFFF, 32'd1,        "neg_one_sq"};
        vecs[7] = '{16'hFFDB, 16'd21,   32'hFFFFFCF7, "neg_exact"};
        vecs[8] = '{16'h8000, 16'h8000, 32'h44100000, "min_sq"};
`else
        vecs[6] = '{16'hFFFF, 16'hFFFF, 32'hF8100000, "max_sq"};
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_r", 64'(r), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;

        for (int i = 0; i < NV; i++) run_vec(vecs[i]);

        // Back-to-back stream of ten pairs.
        sb_en    = 1'b1;
        base     = n_out;
        rdy_drop = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = rand_op();
            b = rand_op();
            if (!in_ready) rdy_drop++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("stream_count", 64'(n_out - base), 64'd10);
        chk("stream_rdy_drop", 64'(rdy_drop), 64'd0);
        chk("stream_queue", 64'(expq.size()), 64'd0);

        // Backpressure: six offered cycles with the sink stalled.
        base = n_acc;
        held = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid  = 1'b1;
            a = rand_op();
            b = rand_op();
            if (i == 4) held = r;
        end
        @(negedge clk);
        chk("bp_accepted", 64'(n_acc - base), 64'd3);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        chk("bp_r_stable", 64'(r), 64'(held));
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a = rand_op();
            b = rand_op();
        end
        @(negedge clk);
        in_valid = 1'b0;
        wait_cyc = 0;
        while (expq.size() != 0 && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        chk("bp_drain", 64'(expq.size()), 64'd0);

        // Reset with two entries in flight.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = rand_op();
        b = rand_op();
        @(negedge clk);
        a = rand_op();
        b = rand_op();
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        #2;
        sb_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_r", 64'(r), 64'd0);
        expq.delete();
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        sb_en     = 1'b1;
        stale     = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("post_rst_stale", 64'(stale), 64'd0);
        chk("post_rst_ready", 64'(in_ready), 64'd1);

        // Randomized traffic with random stalls on both sides.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 4) != 0;
            a = rand_op();
            b = rand_op();
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_cyc  = 0;
        while (expq.size() != 0 && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        chk("rand_drain", 64'(expq.size()), 64'd0);
        sb_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
